// File: rtl/load_extend_pipe_if.sv
// +----------------------------------------------------------------------------+
// | load_extend_pipe_if                                                        |
// | Request/result handshake bundle for load_extend_pipe.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface load_extend_pipe_if #(
  parameter int DATA_W = 32
);
  localparam int OFF_W = $clog2(DATA_W/8);

  logic              InValid;
  logic              InReady;
  logic [DATA_W-1:0] X;
  logic [OFF_W-1:0]  Offset;
  logic [1:0]        Size;
  logic              Signed;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] Y;
  logic              Misalign;

  modport master (
    output InValid, X, Offset, Size, Signed, OutReady,
    input  InReady, OutValid, Y, Misalign
  );

  modport slave (
    input  InValid, X, Offset, Size, Signed, OutReady,
    output InReady, OutValid, Y, Misalign
  );
endinterface

`default_nettype wire

// File: rtl/load_extend_pipe.sv
// +----------------------------------------------------------------------------+
// | load_extend_pipe                                                           |
// | Registered byte/half/word/double field extract and sign/zero extend with   |
// | a 2-entry skid buffer. Optional macro: LEXT_MISALIGN_CHECK_EN.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_extend_pipe #(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  wire logic         Clk,
  input  wire logic         Rst_n,
  load_extend_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_main_y;
  logic              r_main_mis;
  logic [DATA_W-1:0] r_skid_y;
  logic              r_skid_mis;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [1:0]        w_size_eff;
  logic [OFF_W-1:0]  w_low_mask;
  logic [OFF_W-1:0]  w_off;
  logic              w_mis;
  logic [DATA_W-1:0] w_sh;
  logic [DATA_W-1:0] w_word_ext;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_y;

  // A narrow datapath has no doubleword, so it falls back to a word access.
  always_comb begin
    w_size_eff = bus.Size;
    if (DATA_W == 32 && bus.Size == 2'b11) begin
      w_size_eff = 2'b10;
    end
  end

  assign w_low_mask = OFF_W'((4'd1 << w_size_eff) - 4'd1);

`ifdef LEXT_MISALIGN_CHECK_EN
  assign w_off = bus.Offset;
  assign w_mis = |(bus.Offset & w_low_mask);
`else
  assign w_off = bus.Offset & ~w_low_mask;
  assign w_mis = 1'b0;
`endif

  assign w_sh = bus.X >> {w_off, 3'b000};

  generate
    if (DATA_W > 32) begin : g_wide
      assign w_word_ext = {{(DATA_W-32){bus.Signed & w_sh[31]}}, w_sh[31:0]};
    end else begin : g_narrow
      assign w_word_ext = w_sh;
    end
  endgenerate

  always_comb begin
    w_ext = w_sh;
    case (w_size_eff)
      2'b00:   w_ext = {{(DATA_W-8){bus.Signed & w_sh[7]}}, w_sh[7:0]};
      2'b01:   w_ext = {{(DATA_W-16){bus.Signed & w_sh[15]}}, w_sh[15:0]};
      2'b10:   w_ext = w_word_ext;
      default: w_ext = w_sh;
    endcase
  end

  assign w_y = w_mis ? '0 : w_ext;

  assign w_in_xfer  = bus.InValid & bus.InReady;
  assign w_out_xfer = r_out_valid & bus.OutReady;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_main_y    <= '0;
      r_main_mis  <= 1'b0;
      r_skid_y    <= '0;
      r_skid_mis  <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main_y    <= w_y;
            r_main_mis  <= w_mis;
            r_out_valid <= 1'b1;
            r_state     <= ONE;
          end
        end
        ONE: begin
          if (w_in_xfer && !w_out_xfer) begin
            r_skid_y   <= w_y;
            r_skid_mis <= w_mis;
            r_state    <= FULL;
          end else if (w_in_xfer && w_out_xfer) begin
            r_main_y   <= w_y;
            r_main_mis <= w_mis;
          end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            r_main_y   <= r_skid_y;
            r_main_mis <= r_skid_mis;
            r_state    <= ONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= EMPTY;
        end
      endcase
    end
  end

  assign bus.InReady  = Rst_n & (r_state != FULL);
  assign bus.OutValid = r_out_valid;
  assign bus.Y        = r_main_y;
  assign bus.Misalign = r_main_mis;

endmodule

`default_nettype wire
